// File: rtl/filter_tap_router.sv
// Runtime-configurable debug tap router: selects any channel at any filter-chain stage
// for each of NOUT stream outputs. Config is committed at frame boundaries, with optional trigger-gated capture.
module filter_tap_router #(
   parameter int NCHAN       = 8,
   parameter int NOUT        = 4,
   parameter int NSAMP       = 8,
   parameter int AGC_BITS    = 5,
   parameter int FRAME_LEN   = 16,
   parameter int CAPTURE_LEN = 64,
   parameter int HOLDOFF_LEN = 16
) (
   input  logic                          aclk,
   input  logic                          reset_i,
   input  logic [NCHAN*NSAMP*12-1:0]     dat_raw_i,
   input  logic [NCHAN*NSAMP*12-1:0]     dat_filt_i,
   input  logic [NCHAN*NSAMP*AGC_BITS-1:0] dat_agc_i,
   input  logic                          trig_i,
   input  logic                          cfg_wr_i,
   input  logic [7:0]                    cfg_addr_i,
   input  logic [15:0]                   cfg_dat_i,
   output logic                          cfg_err_o,
   output logic [NOUT*NSAMP*16-1:0]      out_tdata,
   output logic [NOUT-1:0]               out_tvalid,
   output logic [NOUT*2-1:0]             cap_state_o
);

   // Outputs are free-running: out_tvalid marks a beat as meaningful; there is no tready
   // and a beat is never held or repeated.

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_HOLDOFF = 2'd2
   } cap_state_e;

   typedef struct packed {
      logic [1:0] mode;
      logic [1:0] stage;
      logic [7:0] chan;
   } cfg_t;

   localparam int FW      = $clog2(FRAME_LEN);
   localparam int CNT_W   = $clog2(CAPTURE_LEN + HOLDOFF_LEN + 1);
   // The IDLE cycle that re-arms the trigger is the last low beat of the holdoff gap,
   // so HOLDOFF itself lasts HOLDOFF_LEN-1 cycles.
   localparam int HO_LAST = (HOLDOFF_LEN > 1) ? HOLDOFF_LEN - 2 : 0;

   logic [FW-1:0]            frame_q, frame_d;
   cfg_t                     pend_q [NOUT];
   cfg_t                     pend_d [NOUT];
   cfg_t                     act_q  [NOUT];
   cfg_t                     act_d  [NOUT];
   cap_state_e               state_q [NOUT];
   cap_state_e               state_d [NOUT];
   logic [CNT_W-1:0]         cnt_q [NOUT];
   logic [CNT_W-1:0]         cnt_d [NOUT];
   logic [NOUT*NSAMP*16-1:0] tdata_q, tdata_d;
   logic [NOUT-1:0]          tvalid_q, tvalid_d;
   logic                     err_q, err_d;
   logic                     commit;
   cfg_t                     wr_cfg;
   logic                     wr_ok;
   int                       base_r;
   int                       base_a;
   logic [15:0]              lane;
   logic                     unused_cfg_bits;

   assign unused_cfg_bits = ^cfg_dat_i[15:12];
   assign wr_cfg = cfg_t'(cfg_dat_i[11:0]);
   assign wr_ok  = (int'(cfg_addr_i) < NOUT) && (int'(cfg_dat_i[7:0]) < NCHAN);
   assign commit = (frame_q == FW'(FRAME_LEN - 1));

   always_comb begin
      frame_d = commit ? '0 : frame_q + 1'b1;
      err_d   = err_q;
      act_d   = act_q;
      pend_d  = pend_q;
      if (commit) act_d = pend_q;
      // A write in the commit cycle lands in pending after the copy above.
      if (cfg_wr_i) begin
         if (wr_ok) begin
            for (int k = 0; k < NOUT; k++) begin
               if (int'(cfg_addr_i) == k) pend_d[k] = wr_cfg;
            end
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_comb begin
      tdata_d = '0;
      base_r  = 0;
      base_a  = 0;
      lane    = '0;
      for (int k = 0; k < NOUT; k++) begin
         for (int s = 0; s < NSAMP; s++) begin
            base_r = int'(act_q[k].chan) * NSAMP * 12 + s * 12;
            base_a = int'(act_q[k].chan) * NSAMP * AGC_BITS + s * AGC_BITS;
            case (act_q[k].stage)
               2'd0:    lane = {dat_raw_i[base_r +: 12], 4'b0000};
               2'd1:    lane = {dat_filt_i[base_r +: 12], 4'b0000};
               2'd2:    lane = 16'(dat_agc_i[base_a +: AGC_BITS]) << 4;
               default: lane = '0;
            endcase
            if (act_q[k].mode[1]) lane = '0;
            tdata_d[k*NSAMP*16 + s*16 +: 16] = lane;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tvalid_d = '0;
      for (int k = 0; k < NOUT; k++) begin
         case (act_q[k].mode)
            2'd0: begin
               tvalid_d[k] = 1'b1;
               state_d[k]  = ST_IDLE;
               cnt_d[k]    = '0;
            end
            2'd1: begin
               case (state_q[k])
                  ST_IDLE: begin
                     if (trig_i) begin
                        state_d[k]  = ST_CAPTURE;
                        cnt_d[k]    = '0;
                        tvalid_d[k] = 1'b1;
                     end
                  end
                  ST_CAPTURE: begin
                     if (cnt_q[k] == CNT_W'(CAPTURE_LEN - 1)) begin
                        cnt_d[k]   = '0;
                        state_d[k] = (HOLDOFF_LEN > 1) ? ST_HOLDOFF : ST_IDLE;
                     end else begin
                        cnt_d[k]    = cnt_q[k] + 1'b1;
                        tvalid_d[k] = 1'b1;
                     end
                  end
                  ST_HOLDOFF: begin
                     if (cnt_q[k] == CNT_W'(HO_LAST)) begin
                        cnt_d[k]   = '0;
                        state_d[k] = ST_IDLE;
                     end else begin
                        cnt_d[k] = cnt_q[k] + 1'b1;
                     end
                  end
                  default: begin
                     state_d[k] = ST_IDLE;
                     cnt_d[k]   = '0;
                  end
               endcase
            end
            default: begin
               state_d[k] = ST_IDLE;
               cnt_d[k]   = '0;
            end
         endcase
         if (commit && (pend_q[k].mode != act_q[k].mode)) begin
            state_d[k] = ST_IDLE;
            cnt_d[k]   = '0;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (reset_i) begin
         frame_q  <= '0;
         err_q    <= 1'b0;
         tdata_q  <= '0;
         tvalid_q <= '0;
         for (int k = 0; k < NOUT; k++) begin
            pend_q[k]  <= '{mode: 2'd0, stage: 2'd0, chan: 8'(k % NCHAN)};
            act_q[k]   <= '{mode: 2'd0, stage: 2'd0, chan: 8'(k % NCHAN)};
            state_q[k] <= ST_IDLE;
            cnt_q[k]   <= '0;
         end
      end else begin
         frame_q  <= frame_d;
         err_q    <= err_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         pend_q   <= pend_d;
         act_q    <= act_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
      end
   end

   assign cfg_err_o  = err_q;
   assign out_tdata  = tdata_q;
   assign out_tvalid = tvalid_q;

   always_comb begin
      cap_state_o = '0;
      for (int k = 0; k < NOUT; k++) cap_state_o[k*2 +: 2] = state_q[k];
   end

endmodule

// File: tb/tb_filter_tap_router.sv
// Directed bench for filter_tap_router: routing, frame-boundary commit, packing,
// trigger capture/holdoff timing, reset abort and config error flag.
module tb_filter_tap_router;

   localparam int NCHAN       = 8;
   localparam int NOUT        = 4;
   localparam int NSAMP       = 8;
   localparam int AGC_BITS    = 5;
   localparam int FRAME_LEN   = 16;
   localparam int CAPTURE_LEN = 64;
   localparam int HOLDOFF_LEN = 16;

   logic                            aclk = 1'b0;
   logic                            reset_i = 1'b1;
   logic [NCHAN*NSAMP*12-1:0]       dat_raw_i = '0;
   logic [NCHAN*NSAMP*12-1:0]       dat_filt_i = '0;
   logic [NCHAN*NSAMP*AGC_BITS-1:0] dat_agc_i = '0;
   logic                            trig_i = 1'b0;
   logic                            cfg_wr_i = 1'b0;
   logic [7:0]                      cfg_addr_i = '0;
   logic [15:0]                     cfg_dat_i = '0;
   logic                            cfg_err_o;
   logic [NOUT*NSAMP*16-1:0]        out_tdata;
   logic [NOUT-1:0]                 out_tvalid;
   logic [NOUT*2-1:0]               cap_state_o;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 aclk = ~aclk;

   filter_tap_router #(
      .NCHAN(NCHAN), .NOUT(NOUT), .NSAMP(NSAMP), .AGC_BITS(AGC_BITS),
      .FRAME_LEN(FRAME_LEN), .CAPTURE_LEN(CAPTURE_LEN), .HOLDOFF_LEN(HOLDOFF_LEN)
   ) dut (
      .aclk(aclk), .reset_i(reset_i), .dat_raw_i(dat_raw_i), .dat_filt_i(dat_filt_i),
      .dat_agc_i(dat_agc_i), .trig_i(trig_i), .cfg_wr_i(cfg_wr_i), .cfg_addr_i(cfg_addr_i),
      .cfg_dat_i(cfg_dat_i), .cfg_err_o(cfg_err_o), .out_tdata(out_tdata),
      .out_tvalid(out_tvalid), .cap_state_o(cap_state_o)
   );

   // cyc numbers the cycle since reset release; sampling and driving happen #1 after the edge.
   task automatic tick();
      @(posedge aclk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      reset_i  = 1'b1;
      cfg_wr_i = 1'b0;
      trig_i   = 1'b0;
      tick();
      tick();
      reset_i = 1'b0;
      cyc     = 0;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) tick();
   endtask

   task automatic cfg_write(input logic [7:0] a, input logic [15:0] d);
      cfg_addr_i = a;
      cfg_dat_i  = d;
      cfg_wr_i   = 1'b1;
      tick();
      cfg_wr_i = 1'b0;
   endtask

   function automatic logic [15:0] lane(input int k, input int s);
      return out_tdata[k*NSAMP*16 + s*16 +: 16];
   endfunction

   function automatic logic [15:0] raw_lane0(input int c);
      return {dat_raw_i[c*NSAMP*12 +: 12], 4'h0};
   endfunction

   task automatic set_base_data();
      dat_raw_i  = '0;
      dat_filt_i = '0;
      dat_agc_i  = '0;
      dat_raw_i[0*NSAMP*12 +: 12]            = 12'h777;
      dat_raw_i[1*NSAMP*12 +: 12]            = 12'h123;
      dat_raw_i[2*NSAMP*12 +: 12]            = 12'hABC;
      dat_raw_i[3*NSAMP*12 +: 12]            = 12'h321;
      dat_filt_i[1*NSAMP*12 +: 12]           = 12'h456;
      dat_agc_i[4*NSAMP*AGC_BITS +: AGC_BITS]            = 5'h1F;
      dat_agc_i[4*NSAMP*AGC_BITS + AGC_BITS +: AGC_BITS] = 5'h0A;
   endtask

   task automatic test_reset();
      set_base_data();
      do_reset();
      total++; if (out_tvalid !== '0) begin bad++; $display("FAIL reset_tvalid got=%h exp=0", out_tvalid); end
      total++; if (out_tdata !== '0) begin bad++; $display("FAIL reset_tdata got nonzero exp=0"); end
      total++; if (cfg_err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", cfg_err_o); end
      total++; if (cap_state_o !== '0) begin bad++; $display("FAIL reset_state got=%h exp=0", cap_state_o); end
   endtask

   task automatic test_default_route();
      tick();
      total++; if (out_tvalid !== 4'hF) begin bad++; $display("FAIL default_tvalid got=%h exp=f", out_tvalid); end
      for (int k = 0; k < NOUT; k++) begin
         total++;
         if (lane(k, 0) !== raw_lane0(k)) begin
            bad++; $display("FAIL default_route out%0d got=%h exp=%h", k, lane(k, 0), raw_lane0(k));
         end
      end
   endtask

   task automatic test_commit();
      logic [15:0] exp;
      run_to(3);
      cfg_write(8'd1, 16'h0002);
      while (cyc <= 17) begin
         exp = (cyc < 17) ? 16'h1230 : 16'hABC0;
         total++;
         if (lane(1, 0) !== exp) begin bad++; $display("FAIL commit cyc=%0d got=%h exp=%h", cyc, lane(1, 0), exp); end
         tick();
      end
   endtask

   task automatic test_write_at_boundary();
      logic [15:0] exp;
      run_to(31);
      cfg_write(8'd1, 16'h0101);
      while (cyc <= 49) begin
         exp = (cyc < 49) ? 16'hABC0 : 16'h4560;
         total++;
         if (lane(1, 0) !== exp) begin bad++; $display("FAIL boundary_write cyc=%0d got=%h exp=%h", cyc, lane(1, 0), exp); end
         tick();
      end
   endtask

   task automatic test_agc_zero();
      cfg_write(8'd2, 16'h0204);
      cfg_write(8'd3, 16'h0300);
      run_to(64);
      total++; if (lane(2, 0) !== 16'hABC0) begin bad++; $display("FAIL agc_before got=%h exp=abc0", lane(2, 0)); end
      tick();
      total++; if (lane(2, 0) !== 16'h01F0) begin bad++; $display("FAIL agc_lane0 got=%h exp=01f0", lane(2, 0)); end
      total++; if (lane(2, 1) !== 16'h00A0) begin bad++; $display("FAIL agc_lane1 got=%h exp=00a0", lane(2, 1)); end
      total++;
      if (out_tdata[3*NSAMP*16 +: NSAMP*16] !== '0) begin bad++; $display("FAIL zero_stage out3 got nonzero exp=0"); end
      total++; if (out_tvalid !== 4'hF) begin bad++; $display("FAIL agc_zero_tvalid got=%h exp=f", out_tvalid); end
   endtask

   task automatic test_capture_pulse();
      logic exp;
      do_reset();
      cfg_write(8'd0, 16'h0400);
      while (cyc <= 260) begin
         exp = (cyc <= 16) || (cyc >= 101 && cyc <= 164) || (cyc >= 182 && cyc <= 245);
         total++;
         if (out_tvalid[0] !== exp) begin bad++; $display("FAIL pulse_tvalid cyc=%0d got=%b exp=%b", cyc, out_tvalid[0], exp); end
         if (cyc == 101 || cyc == 164) begin
            total++;
            if (lane(0, 0) !== {12'(cyc - 1), 4'h0}) begin
               bad++; $display("FAIL capture_data cyc=%0d got=%h exp=%h", cyc, lane(0, 0), {12'(cyc - 1), 4'h0});
            end
         end
         if (cyc == 130) begin
            total++; if (cap_state_o[1:0] !== 2'd1) begin bad++; $display("FAIL state_capture got=%0d exp=1", cap_state_o[1:0]); end
         end
         if (cyc == 170) begin
            total++; if (cap_state_o[1:0] !== 2'd2) begin bad++; $display("FAIL state_holdoff got=%0d exp=2", cap_state_o[1:0]); end
         end
         trig_i = (cyc == 100) || (cyc == 130) || (cyc == 170) || (cyc == 181);
         dat_raw_i[0 +: 12] = 12'(cyc);
         tick();
      end
      trig_i = 1'b0;
      set_base_data();
   endtask

   task automatic test_capture_continuous();
      logic exp;
      do_reset();
      cfg_write(8'd0, 16'h0400);
      while (cyc <= 269) begin
         exp = (cyc <= 16) || (cyc >= 21 && ((cyc - 21) % 80) < 64);
         total++;
         if (out_tvalid[0] !== exp) begin bad++; $display("FAIL cont_tvalid cyc=%0d got=%b exp=%b", cyc, out_tvalid[0], exp); end
         trig_i = (cyc >= 20);
         tick();
      end
      total++; if (out_tvalid[0] !== 1'b1) begin bad++; $display("FAIL mid_capture_tvalid got=%b exp=1", out_tvalid[0]); end
      total++; if (cap_state_o[1:0] !== 2'd1) begin bad++; $display("FAIL mid_capture_state got=%0d exp=1", cap_state_o[1:0]); end
      reset_i = 1'b1;
      tick();
      total++; if (out_tvalid !== '0) begin bad++; $display("FAIL abort_tvalid got=%h exp=0", out_tvalid); end
      total++; if (cap_state_o !== '0) begin bad++; $display("FAIL abort_state got=%h exp=0", cap_state_o); end
      reset_i = 1'b0;
      trig_i  = 1'b0;
   endtask

   task automatic test_cfg_error();
      do_reset();
      total++; if (cfg_err_o !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", cfg_err_o); end
      cfg_write(8'd0, 16'h0008);
      total++; if (cfg_err_o !== 1'b1) begin bad++; $display("FAIL err_bad_chan got=%b exp=1", cfg_err_o); end
      run_to(17);
      total++; if (lane(0, 0) !== 16'h7770) begin bad++; $display("FAIL bad_chan_ignored got=%h exp=7770", lane(0, 0)); end
      do_reset();
      total++; if (cfg_err_o !== 1'b0) begin bad++; $display("FAIL err_reset got=%b exp=0", cfg_err_o); end
      cfg_write(8'(NOUT), 16'h0001);
      total++; if (cfg_err_o !== 1'b1) begin bad++; $display("FAIL err_bad_addr got=%b exp=1", cfg_err_o); end
      run_to(40);
      total++; if (cfg_err_o !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", cfg_err_o); end
      for (int k = 0; k < NOUT; k++) begin
         total++;
         if (lane(k, 0) !== raw_lane0(k)) begin
            bad++; $display("FAIL bad_addr_ignored out%0d got=%h exp=%h", k, lane(k, 0), raw_lane0(k));
         end
      end
      do_reset();
      total++; if (cfg_err_o !== 1'b0) begin bad++; $display("FAIL err_final_reset got=%b exp=0", cfg_err_o); end
   endtask

   initial begin
      test_reset();
      test_default_route();
      test_commit();
      test_write_at_boundary();
      test_agc_zero();
      test_capture_pulse();
      test_capture_continuous();
      test_cfg_error();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/filter_tap_router.md
Name: filter_tap_router

Overview:
- Parametrised successor to the fixed debug tap wiring on the filter chain.
- Routes any channel at any chain stage (raw ADC, filtered, AGC-scaled) to any of NOUT AXI4-Stream buffer/DAC outputs.
- Routing is runtime-selectable. Changes are committed only at frame boundaries.
- Each output can stream continuously, or emit trigger-gated capture windows with holdoff.

Parameters:
NCHAN, 8, number of input channels (≤256)
NOUT, 4, number of routed outputs
NSAMP, 8, samples per beat
AGC_BITS, 5, AGC-stage sample width (≤12)
FRAME_LEN, 16, beats per commit frame (≥2)
CAPTURE_LEN, 64, beats of tvalid per trigger capture (≥1)
HOLDOFF_LEN, 16, beats after a capture during which triggers are ignored (≥0)

Ports:
aclk  in  1  stream clock
reset_i  in  1  synchronous active-high reset
dat_raw_i  in  NCHAN*NSAMP*12  unpacked ADC samples, channel c at [c*NSAMP*12 +: NSAMP*12]
dat_filt_i  in  NCHAN*NSAMP*12  filter-chain output, same layout
dat_agc_i  in  NCHAN*NSAMP*AGC_BITS  AGC output, channel c at [c*NSAMP*AGC_BITS +: NSAMP*AGC_BITS]
trig_i  in  1  trigger (OR of beam triggers), level-sampled each cycle
cfg_wr_i  in  1  config write strobe
cfg_addr_i  in  8  output index
cfg_dat_i  in  16  [7:0] chan, [9:8] stage (0 raw, 1 filt, 2 agc, 3 zero), [11:10] mode (0 continuous, 1 triggered, 2/3 off)
cfg_err_o  out  1  sticky: rejected write
out_tdata  out  NOUT*NSAMP*16  output k at [k*NSAMP*16 +: NSAMP*16]
out_tvalid  out  NOUT  per-output valid

Behaviour:
- Reset (reset_i high at an aclk edge) sets:
  - out_tdata=0, out_tvalid=0, cfg_err_o=0, frame counter=0.
  - Active and pending config for output k: chan=k mod NCHAN, stage=0, mode=0.
  - All capture FSMs in IDLE.
- Reset mid-capture aborts the capture. tvalid=0 on the next cycle.
- Config write: if cfg_wr_i=1 and cfg_addr_i<NOUT and chan<NCHAN, cfg_dat_i is stored to pending[cfg_addr_i].
  - Otherwise the write is discarded and cfg_err_o is set. It clears only on reset.
- Frame counter: counts 0..FRAME_LEN-1 and wraps. When the counter is at FRAME_LEN-1, every pending config is copied to active.
  - A write in that same cycle lands in pending after the copy, so it commits at the next boundary.
  - New active config governs from the next cycle.
  - An output whose mode changes at commit has its capture FSM forced to IDLE.
- Packing, 16-bit lanes:
  - 12-bit stages: sample in lane bits [15:4], bits [3:0]=0.
  - AGC stage: sample in bits [4 +: AGC_BITS], all other lane bits 0.
  - Stage 3: all zeros.
- Datapath latency: exactly 1 cycle. out_tdata at cycle t+1 is pack(select(dat_*_i at t)).
  - out_tdata is updated every cycle regardless of tvalid, except in mode 2/3, where it is 0.
- Mode 0: out_tvalid=1 every cycle.
- Mode 2/3: out_tvalid=0.
- Mode 1 per-output FSM:
  - IDLE, tvalid=0: trig_i=1 at cycle t goes to CAPTURE. tvalid=1 for cycles t+1..t+CAPTURE_LEN, so the captured data starts with samples from cycle t.
  - CAPTURE, tvalid=1: counts CAPTURE_LEN beats, then goes to HOLDOFF, or to IDLE if HOLDOFF_LEN=0. trig_i is ignored.
  - HOLDOFF, tvalid=0: counts HOLDOFF_LEN beats, then goes to IDLE. trig_i is ignored.
  - The first trigger honoured in IDLE is the cycle immediately after HOLDOFF ends.
- trig_i held high continuously produces a periodic capture with period CAPTURE_LEN+HOLDOFF_LEN beats.
- A trigger in the commit cycle is evaluated against the old active config.
- No tready: outputs are free-running, with no backpressure.

Test Plan:
- Reset, then release; drive channel 2 raw sample 0 = 12'hABC. Write out1 chan=2 stage=0 mode=0 at counter=3. Out1 lane0 = 16'hABC0 from cycle 17 after release (commit at counter 15 of frame 0 → new active from cycle 16 → data out at cycle 17). Before that, out1 shows channel 1.
- Write at exactly counter=15: the change does not commit until the counter reaches 15 in the following frame; output unchanged for 16 more cycles.
- AGC stage, AGC_BITS=5, sample 5'h1F → lane = 16'h01F0. Stage 3 → all zeros with tvalid=1.
- Mode 1, CAPTURE_LEN=64, HOLDOFF_LEN=16; single trig_i pulse at cycle 100: tvalid high for cycles 101..164, low after. Pulses at 130 and 170 are ignored; a pulse at 181 triggers a capture.
- trig_i held high in mode 1: tvalid pattern is 64 high / 16 low, repeating. Reset asserted mid-capture → tvalid=0 the next cycle, FSM in IDLE.
- Write with cfg_addr_i=NOUT, and a write with chan=NCHAN: no config change, cfg_err_o=1 and stays 1 until reset.
